nios_system_cpu_mul_seq: RTL and testbench
==========================================

// Module: nios_system_CPU_mul_seq
// PURPOSE
//  Multiply sequencer directly upstream of the CPU 32x32 multiply cell. It accepts one multiply
//  request at a time, drives the cell's operand inputs, waits out the cell latency and
//  accumulates the cell results. It returns the 32-bit result over a valid/ready handshake.
//  MUL (low word) uses one full-width pass. MULXUU/MULXSU/MULXSS (high word) use four 16x16
//  passes through the same cell, followed by a signed-correction step.
// PARAMETERS
//  CELL_LATENCY  1  cycles from operands on mul_src1/2 (sampled at an edge) to valid mul_cell_result; legal 1..4
// PORTS
//  clk              in   1   single clock
//  reset            in   1   synchronous, active-high reset
//  abort            in   1   pipeline flush; cancels any op in flight
//  req_valid        in   1   request present
//  req_ready        out  1   sequencer can accept a request
//  req_op           in   2   00 MUL, 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS
//  req_src1         in   32  operand A
//  req_src2         in   32  operand B
//  resp_valid       out  1   result present
//  resp_ready       in   1   consumer takes result
//  resp_data        out  32  result word
//  mul_src1         out  32  to multiply cell operand 1
//  mul_src2         out  32  to multiply cell operand 2
//  mul_cell_result  in   32  from multiply cell: low 32 bits of mul_src1*mul_src2, CELL_LATENCY cycles after the operands
// BEHAVIOUR
//  Reset (sync): state IDLE, resp_valid=0, resp_data=0, mul_src1/2=0, acc=0, pass=0, wait count=0.
//  States: IDLE -> RUN -> (CORR for MULX*) -> DONE -> IDLE.
//  IDLE: req_ready = ~abort.
//   - On req_valid & req_ready: register op and operands, acc=0, pass=0, count=0, go to RUN.
//   - mul_src1/2 = 0 in IDLE.
//  RUN: hold mul_src1/2 for the current pass; count increments each cycle.
//   - When count == CELL_LATENCY: sample mul_cell_result into acc, clear count, advance pass.
//   - Each pass lasts CELL_LATENCY+1 cycles.
//   - MUL: one pass with src1/src2 at full width; acc[31:0] = result. Then go to DONE.
//   - MULX*: four passes; halves are zero-extended to 32 bits (aL=A[15:0], aH=A[31:16], same for B).
//       pass0 aL*bL: acc += r
//       pass1 aH*bL: acc += r<<16
//       pass2 aL*bH: acc += r<<16
//       pass3 aH*bH: acc += r<<32
//     acc is 64 bits wide. After pass3, go to CORR.
//  CORR (1 cycle): hi = acc[63:32]
//   - minus (B if op is MULXSS and A[31]=1; MULXSU with A[31]=1 also subtracts B)
//   - minus (A if op is MULXSS and B[31]=1)
//   - Arithmetic is modulo 2^32. Go to DONE.
//  DONE: resp_valid=1; resp_data = acc[31:0] (MUL) or the corrected hi (MULX*).
//   - Data is held stable until resp_ready. On the handshake, go to IDLE.
//   - req_ready=0 in DONE, so the next request is accepted no earlier than the following cycle.
//  Latency, accept at edge T: resp_valid first high in cycle T+CELL_LATENCY+2 (MUL) or T+4*CELL_LATENCY+6 (MULX*).
//   With CELL_LATENCY=1 that is T+3 and T+10.
//  abort (any state): next cycle IDLE, resp_valid=0, mul_src=0, no response is ever produced.
//   - abort & req_valid in IDLE: request is not accepted.
//   - abort in DONE while resp_ready=1: abort wins; the result is counted as not delivered.
//  reset has priority over abort. reset mid-op behaves as abort and also clears resp_data.
//  req_* inputs are ignored outside IDLE; operands are taken only from the internal registers.
// TESTING
//  1 MUL A=0x0001_0003 B=0x0002_0005, resp_ready=1 -> resp_data=0x000B_000F, resp_valid at T+3 for 1 cycle.
//  2 MULXUU A=B=0xFFFF_FFFF -> resp_data=0xFFFF_FFFE at T+10; mul_src sequence FFFF/FFFF x4 halves observed.
//  3 MULXSS A=0xFFFF_FFFF B=0x0000_0002 -> 0xFFFF_FFFF.
//    MULXSU A=0x8000_0000 B=0xFFFF_FFFF -> 0x8000_0000.
//    MULXSS A=B=0x8000_0000 -> 0x4000_0000.
//  4 Backpressure: MUL with resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0 throughout.
//    req_ready=1 the cycle after the handshake.
//  5 abort during pass2 of MULXUU -> no resp_valid ever; IDLE/req_ready=1 next cycle; mul_src=0.
//    A following MUL 7*6 returns 42.
//  6 reset asserted in CORR -> next cycle all outputs at reset values. Repeat with CELL_LATENCY=3: MUL at T+5, MULX* at T+18.

Source files
------------

// File: rtl/nios_system_cpu_mul_seq.sv
// Multiply sequencer feeding an external 32x32 multiply cell (low-word result,
// CELL_LATENCY cycles). MUL uses one full-width pass; MULXUU/MULXSU/MULXSS run
// four 16x16 passes plus a signed correction of the high word.
// Ports: clk/reset (sync, active-high), abort (flush), req_* request handshake,
// resp_* result handshake, mul_src1/2 -> cell, mul_cell_result <- cell.
module nios_system_cpu_mul_seq #(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CORR, S_DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS} op_t;

  localparam logic [2:0] LAT = 3'(CELL_LATENCY);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [1:0]  pass_q, pass_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;

  logic [63:0] r64;
  logic [63:0] term;
  logic [31:0] sub_a, sub_b, hi_corr;
  logic [63:0] next_ops;

  // Operand pair {src1, src2} for a given pass; MULX passes use zero-extended halves.
  function automatic logic [63:0] pass_ops(input op_t op, input logic [1:0] p,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s1, s2;
    if (op == OP_MUL) begin
      s1 = a;
      s2 = b;
    end else begin
      s1 = p[0] ? {16'h0000, a[31:16]} : {16'h0000, a[15:0]};
      s2 = p[1] ? {16'h0000, b[31:16]} : {16'h0000, b[15:0]};
    end
    return {s1, s2};
  endfunction

  assign req_ready  = (state_q == S_IDLE) && !abort;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;

  always_comb begin
    r64 = {32'h0000_0000, mul_cell_result};
    case (pass_q)
      2'd0:    term = r64;
      2'd1,
      2'd2:    term = r64 << 16;
      default: term = r64 << 32;
    endcase
    // Unsigned high word corrected to signed: subtract B when A is negative
    // (SU and SS), subtract A when B is negative (SS only).
    sub_b   = (op_q[1] && a_q[31]) ? b_q : '0;
    sub_a   = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : '0;
    hi_corr = acc_q[63:32] - sub_b - sub_a;
    next_ops = pass_ops(op_q, pass_q + 2'd1, a_q, b_q);
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    pass_d       = pass_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    src1_d       = src1_q;
    src2_d       = src2_q;

    case (state_q)
      S_IDLE: begin
        src1_d = '0;
        src2_d = '0;
        if (req_valid && req_ready) begin
          op_d   = op_t'(req_op);
          a_d    = req_src1;
          b_d    = req_src2;
          acc_d  = '0;
          pass_d = '0;
          cnt_d  = '0;
          {src1_d, src2_d} = pass_ops(op_t'(req_op), 2'd0, req_src1, req_src2);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == LAT) begin
          cnt_d = '0;
          if (op_q == OP_MUL) begin
            acc_d        = r64;
            resp_data_d  = mul_cell_result;
            resp_valid_d = 1'b1;
            src1_d       = '0;
            src2_d       = '0;
            state_d      = S_DONE;
          end else begin
            acc_d = acc_q + term;
            if (pass_q == 2'd3) begin
              src1_d  = '0;
              src2_d  = '0;
              state_d = S_CORR;
            end else begin
              pass_d           = pass_q + 2'd1;
              {src1_d, src2_d} = next_ops;
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_CORR: begin
        resp_data_d  = hi_corr;
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      default: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      src1_d       = '0;
      src2_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MUL;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      pass_q       <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      pass_q       <= pass_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_mul_seq.sv
module tb_nios_system_cpu_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        reset      [2];
  logic        abort      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [1:0]  req_op     [2];
  logic [31:0] req_src1   [2];
  logic [31:0] req_src2   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic [31:0] mul_src1   [2];
  logic [31:0] mul_src2   [2];
  logic [31:0] cell_res   [2];

  // Instance 0 uses CELL_LATENCY=1, instance 1 uses CELL_LATENCY=3.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [31:0] pipe [4];

    nios_system_cpu_mul_seq #(.CELL_LATENCY(L)) dut (
      .clk             (clk),
      .reset           (reset[g]),
      .abort           (abort[g]),
      .req_valid       (req_valid[g]),
      .req_ready       (req_ready[g]),
      .req_op          (req_op[g]),
      .req_src1        (req_src1[g]),
      .req_src2        (req_src2[g]),
      .resp_valid      (resp_valid[g]),
      .resp_ready      (resp_ready[g]),
      .resp_data       (resp_data[g]),
      .mul_src1        (mul_src1[g]),
      .mul_src2        (mul_src2[g]),
      .mul_cell_result (cell_res[g])
    );

    // Multiply cell model: low 32 bits of the product, L cycles after the operands.
    always @(posedge clk) begin
      pipe[0] <= mul_src1[g] * mul_src2[g];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign cell_res[g] = pipe[L-1];
  end

  typedef struct {
    logic [31:0] data;
    int          t;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb [2][$];
  bit   seen [2] = '{0, 0};

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [10] = '{
    '{2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F},
    '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{2'd1, 32'h0002_0003, 32'h0004_0005, 32'h0000_0008},
    '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
    '{2'd1, 32'h0001_FFFF, 32'h0001_FFFF, 32'h0000_0003}
  };

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset[g] && resp_valid[g]) begin
        if (sb[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp inst%0d: got data %h expected no response", g, resp_data[g]);
        end else begin
          if (!seen[g]) begin
            seen[g] = 1'b1;
            chk({sb[g][0].name, "_latency"}, 32'(cyc + 1 - sb[g][0].t), 32'(sb[g][0].lat));
          end
          chk(sb[g][0].name, resp_data[g], sb[g][0].data);
          if (resp_ready[g] && !abort[g]) begin
            void'(sb[g].pop_front());
            seen[g] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input bit push, input string name);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_src1[i]  = a;
    req_src2[i]  = b;
    n = 0;
    while (!req_ready[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got req_ready 0 expected 1", name);
    end else if (push) begin
      e.data = res;
      e.t    = cyc + 1;
      e.lat  = lat;
      e.name = name;
      sb[i].push_back(e);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_op[i]    = $urandom_range(0, 3);
    req_src1[i]  = $urandom;
    req_src2[i]  = $urandom;
  endtask

  task automatic drain(input int i, input string name);
    int n = 0;
    while (sb[i].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb[i].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_resp_timeout: got no response expected %h", name, sb[i][0].data);
      sb[i].delete();
      seen[i] = 1'b0;
    end
  endtask

  // Called in the first RUN cycle; checks cell operands across the four MULX passes.
  task automatic src_seq(input int i, input int L, input logic [31:0] a, input logic [31:0] b,
                         input string name);
    logic [31:0] e1, e2;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      if (p != 0) repeat (L + 1) @(negedge clk);
      e1 = (p % 2 == 1) ? {16'h0, a[31:16]} : {16'h0, a[15:0]};
      e2 = (p >= 2)     ? {16'h0, b[31:16]} : {16'h0, b[15:0]};
      chk($sformatf("%s_src1_pass%0d", name, p), mul_src1[i], e1);
      chk($sformatf("%s_src2_pass%0d", name, p), mul_src2[i], e2);
    end
  endtask

  task automatic run_suite(input int i);
    int    L  = (i == 0) ? 1 : 3;
    int    ml = L + 2;
    int    xl = 4 * L + 6;
    int    n;
    string nm;

    for (int v = 0; v < 10; v++) begin
      nm = $sformatf("L%0d_vec%0d", L, v);
      issue(i, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].res, (vecs[v].op == 2'd0) ? ml : xl, 1'b1, nm);
      if (v == 1 || v == 3) src_seq(i, L, vecs[v].a, vecs[v].b, nm);
      drain(i, nm);
    end

    // Backpressure: result held while the consumer stalls.
    nm = $sformatf("L%0d_bp", L);
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    issue(i, 2'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, ml, 1'b1, nm);
    n = 0;
    while (!resp_valid[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk({nm, "_valid_held"}, 32'(resp_valid[i]), 32'd1);
      chk({nm, "_req_ready_low"}, 32'(req_ready[i]), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_req_ready_after"}, 32'(req_ready[i]), 32'd1);
    chk({nm, "_valid_after"}, 32'(resp_valid[i]), 32'd0);
    drain(i, nm);

    // Abort in the first cycle of pass 2.
    nm = $sformatf("L%0d_abort", L);
    issue(i, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, xl, 1'b0, nm);
    repeat (2 * (L + 1)) begin
      @(posedge clk); #1;
    end
    abort[i] = 1'b1;
    @(posedge clk); #1;
    abort[i] = 1'b0;
    @(negedge clk);
    chk({nm, "_req_ready"}, 32'(req_ready[i]), 32'd1);
    chk({nm, "_src1"}, mul_src1[i], 32'h0);
    chk({nm, "_src2"}, mul_src2[i], 32'h0);
    chk({nm, "_valid"}, 32'(resp_valid[i]), 32'd0);
    repeat (4 * L + 8) @(negedge clk);
    issue(i, 2'd0, 32'd7, 32'd6, 32'd42, ml, 1'b1, {nm, "_mul7x6"});
    drain(i, nm);

    // Reset asserted during the correction cycle.
    nm = $sformatf("L%0d_reset", L);
    issue(i, 2'd3, 32'h8000_0000, 32'h8000_0000, '0, xl, 1'b0, nm);
    repeat (4 * L + 4) begin
      @(posedge clk); #1;
    end
    reset[i] = 1'b1;
    @(posedge clk); #1;
    reset[i] = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(resp_valid[i]), 32'd0);
    chk({nm, "_data"}, resp_data[i], 32'h0);
    chk({nm, "_src1"}, mul_src1[i], 32'h0);
    chk({nm, "_src2"}, mul_src2[i], 32'h0);
    chk({nm, "_req_ready"}, 32'(req_ready[i]), 32'd1);
    repeat (4 * L + 8) @(negedge clk);
    issue(i, 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, xl, 1'b1, {nm, "_after"});
    drain(i, nm);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i]      = 1'b1;
      abort[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_op[i]     = 2'd0;
      req_src1[i]   = '0;
      req_src2[i]   = '0;
      resp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("inst%0d_rst_valid", i), 32'(resp_valid[i]), 32'd0);
      chk($sformatf("inst%0d_rst_data", i), resp_data[i], 32'h0);
      chk($sformatf("inst%0d_rst_src1", i), mul_src1[i], 32'h0);
      chk($sformatf("inst%0d_rst_src2", i), mul_src2[i], 32'h0);
      chk($sformatf("inst%0d_rst_req_ready", i), 32'(req_ready[i]), 32'd1);
    end
    @(posedge clk); #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    run_suite(0);
    run_suite(1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
